fb_rect_fill: RTL and testbench

FB_RECT_FILL -- requirements
Module: fb_rect_fill

---
 rtl/fb_pkg.sv | 17 +
 rtl/fb_rect_fill.sv | 187 ++++++++++++++++++
 tb/tb_fb_rect_fill.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared framebuffer geometry and fill-engine state encoding.
// The VGA scan-out logic imports this package as well.
package fb_pkg;

  localparam int FB_H_RES   = 320;
  localparam int FB_V_RES   = 240;
  localparam int FB_COLOR_W = 12;
  localparam int FB_ADDR_W  = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLIP = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } fb_fill_state_e;

endpackage

// File: rtl/fb_rect_fill.sv
// Rectangle fill engine: clips a command to the framebuffer and writes one
// pixel per cycle in raster order through the RAM write port.
module fb_rect_fill
  import fb_pkg::*;
#(
  parameter int H_RES   = FB_H_RES,
  parameter int V_RES   = FB_V_RES,
  parameter int COLOR_W = FB_COLOR_W,
  parameter int ADDR_W  = FB_ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [8:0]         cmd_x0,
  input  logic [7:0]         cmd_y0,
  input  logic [8:0]         cmd_w,
  input  logic [7:0]         cmd_h,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [COLOR_W-1:0] wr_data,
  output logic               busy,
  output logic               done
);

  localparam logic [9:0] H_LIM = 10'(H_RES);
  localparam logic [9:0] V_LIM = 10'(V_RES);

  fb_fill_state_e state_q, state_d;

  logic [8:0]         x0_q, x0_d;
  logic [7:0]         y0_q, y0_d;
  logic [8:0]         w_q, w_d;
  logic [7:0]         h_q, h_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [8:0]         x_q, x_d;
  logic [7:0]         y_q, y_d;
  logic [9:0]         x_end_q, x_end_d;
  logic [9:0]         y_end_q, y_end_d;
  logic [ADDR_W-1:0]  row_base_q, row_base_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [COLOR_W-1:0] wr_data_q, wr_data_d;

  logic [9:0]         x_sum, y_sum, x_lim, y_lim, x_inc, y_inc;
  logic               empty;
  logic [ADDR_W-1:0]  row_first;

  always_comb begin
    x_sum     = {1'b0, x0_q} + {1'b0, w_q};
    y_sum     = {2'b00, y0_q} + {2'b00, h_q};
    x_lim     = (x_sum > H_LIM) ? H_LIM : x_sum;
    y_lim     = (y_sum > V_LIM) ? V_LIM : y_sum;
    empty     = (w_q == '0) || (h_q == '0) ||
                ({1'b0, x0_q} >= H_LIM) || ({2'b00, y0_q} >= V_LIM);
    x_inc     = {1'b0, x_q} + 10'd1;
    y_inc     = {2'b00, y_q} + 10'd1;
    // One multiply per command for the first row; rows then advance by H_RES.
    row_first = ADDR_W'(y0_q) * ADDR_W'(H_RES);
  end

  always_comb begin
    state_d    = state_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    x_d        = x_q;
    y_d        = y_q;
    x_end_d    = x_end_q;
    y_end_d    = y_end_q;
    row_base_d = row_base_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    wr_data_d  = '0;
    done_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          x0_d    = cmd_x0;
          y0_d    = cmd_y0;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = CLIP;
        end
      end
      CLIP: begin
        x_end_d = x_lim;
        y_end_d = y_lim;
        if (empty) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          state_d    = FILL;
          x_d        = x0_q;
          y_d        = y0_q;
          row_base_d = row_first;
          wr_en_d    = 1'b1;
          wr_addr_d  = row_first + ADDR_W'(x0_q);
          wr_data_d  = color_q;
        end
      end
      FILL: begin
        // wr_* registers hold pixel (x_q, y_q); here we stage the next one.
        if (x_inc < x_end_q) begin
          x_d       = x_inc[8:0];
          wr_en_d   = 1'b1;
          wr_addr_d = row_base_q + ADDR_W'(x_inc);
          wr_data_d = color_q;
        end else if (y_inc < y_end_q) begin
          x_d        = x0_q;
          y_d        = y_inc[7:0];
          row_base_d = row_base_q + ADDR_W'(H_RES);
          wr_en_d    = 1'b1;
          wr_addr_d  = row_base_q + ADDR_W'(H_RES) + ADDR_W'(x0_q);
          wr_data_d  = color_q;
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    cmd_ready_d = (state_d == IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      color_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      x_end_q     <= '0;
      y_end_q     <= '0;
      row_base_q  <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      x0_q        <= x0_d;
      y0_q        <= y0_d;
      w_q         <= w_d;
      h_q         <= h_d;
      color_q     <= color_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x_end_q     <= x_end_d;
      y_end_q     <= y_end_d;
      row_base_q  <= row_base_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Bench for fb_rect_fill: directed corner cases plus random rectangles,
// each cycle checked against an arithmetic model of the clipped raster walk.
module tb_fb_rect_fill;

  localparam int H = 320;
  localparam int V = 240;

  typedef struct {
    int x0;
    int y0;
    int w;
    int h;
    int color;
  } cmd_t;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  cmd_x0;
  logic [7:0]  cmd_y0;
  logic [8:0]  cmd_w;
  logic [7:0]  cmd_h;
  logic [11:0] cmd_color;
  logic        wr_en;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        busy;
  logic        done;

  int vectors;
  int miscompares;

  fb_rect_fill #(
    .H_RES  (320),
    .V_RES  (240),
    .COLOR_W(12),
    .ADDR_W (17)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_x0   (cmd_x0),
    .cmd_y0   (cmd_y0),
    .cmd_w    (cmd_w),
    .cmd_h    (cmd_h),
    .cmd_color(cmd_color),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [32:0] pack(input bit rdy, input bit bsy, input bit dn,
                                       input bit we, input int addr, input int data);
    logic [16:0] a;
    logic [11:0] d;
    a = 17'(addr);
    d = 12'(data);
    return {rdy, bsy, dn, we, a, d};
  endfunction

  function automatic logic [32:0] observed();
    return {cmd_ready, busy, done, wr_en, wr_addr, wr_data};
  endfunction

  task automatic chk(input string tag, input int cyc, input logic [32:0] exp);
    logic [32:0] obs;
    obs = observed();
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s cyc=%0d observed {rdy,busy,done,we,addr,data}=%h expected=%h",
             tag, cyc, obs, exp);
    end
  endtask

  task automatic drive(input cmd_t c);
    cmd_valid = 1'b1;
    cmd_x0    = 9'(c.x0);
    cmd_y0    = 8'(c.y0);
    cmd_w     = 9'(c.w);
    cmd_h     = 8'(c.h);
    cmd_color = 12'(c.color);
  endtask

  // Clipped width/height straight from the rectangle rules.
  function automatic int clip_len(input int start, input int len, input int lim);
    int e;
    if (len == 0 || start >= lim) return 0;
    e = start + len;
    if (e > lim) e = lim;
    return e - start;
  endfunction

  // Called at the negedge of an idle cycle; that cycle is cycle 0 (accept).
  // With chain set, cmd_valid stays high with command b from cycle 1 onward.
  task automatic run_cmd(input string tag, input cmd_t a, input bit chain, input cmd_t b);
    int cw, ch, n, i, px, py;
    cw = clip_len(a.x0, a.w, H);
    ch = clip_len(a.y0, a.h, V);
    n  = cw * ch;
    chk({tag, "_c0"}, 0, pack(1, 0, 0, 0, 0, 0));
    drive(a);
    for (int j = 1; j <= n + 3; j++) begin
      @(negedge clk);
      if (j == 1) begin
        if (chain) drive(b);
        else cmd_valid = 1'b0;
      end
      if (j >= 2 && j <= n + 1) begin
        i  = j - 2;
        px = a.x0 + (i % cw);
        py = a.y0 + (i / cw);
        chk(tag, j, pack(0, 1, 0, 1, py * H + px, a.color));
      end else if (j == n + 2) begin
        chk({tag, "_done"}, j, pack(0, 1, 1, 0, 0, 0));
      end else if (j == n + 3) begin
        chk({tag, "_ready"}, j, pack(1, 0, 0, 0, 0, 0));
      end else begin
        chk({tag, "_clip"}, j, pack(0, 1, 0, 0, 0, 0));
      end
    end
  endtask

  cmd_t c, c2;

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_x0      = '0;
    cmd_y0      = '0;
    cmd_w       = '0;
    cmd_h       = '0;
    cmd_color   = '0;

    @(negedge clk);
    chk("reset_state", 0, pack(1, 0, 0, 0, 0, 0));
    cmd_valid = 1'b1;
    cmd_w     = 9'd5;
    cmd_h     = 8'd5;
    @(negedge clk);
    chk("reset_ignores_valid", 0, pack(1, 0, 0, 0, 0, 0));
    cmd_valid = 1'b0;
    reset     = 1'b1;
    @(negedge clk);

    c = '{x0: 319, y0: 239, w: 1, h: 1, color: 'h5A3};
    run_cmd("corner", c, 0, c);

    c = '{x0: 310, y0: 1, w: 20, h: 2, color: 'h0C7};
    run_cmd("clip", c, 0, c);

    c = '{x0: 12, y0: 7, w: 0, h: 9, color: 'hFFF};
    run_cmd("empty_w0", c, 0, c);

    c = '{x0: 320, y0: 7, w: 4, h: 3, color: 'h123};
    run_cmd("empty_x320", c, 0, c);

    c = '{x0: 3, y0: 240, w: 4, h: 3, color: 'h321};
    run_cmd("empty_y240", c, 0, c);

    c  = '{x0: 100, y0: 50, w: 3, h: 2, color: 'hABC};
    c2 = '{x0: 0, y0: 238, w: 2, h: 5, color: 'h0F0};
    run_cmd("b2b_first", c, 1, c2);
    run_cmd("b2b_second", c2, 0, c2);

    for (int k = 0; k < 14; k++) begin
      c.x0    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 330)) : int'($urandom_range(0, 319));
      c.y0    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(232, 245)) : int'($urandom_range(0, 239));
      c.w     = int'($urandom_range(0, 24));
      c.h     = int'($urandom_range(0, 8));
      c.color = int'($urandom_range(0, 4095));
      run_cmd("random", c, 0, c);
    end

    c = '{x0: 0, y0: 0, w: 320, h: 240, color: 'hF00};
    run_cmd("full", c, 0, c);

    chk("rst_pre", 0, pack(1, 0, 0, 0, 0, 0));
    drive(c);
    for (int j = 1; j <= 101; j++) begin
      @(negedge clk);
      if (j == 1) cmd_valid = 1'b0;
      if (j >= 2) chk("rst_fill", j, pack(0, 1, 0, 1, j - 2, 'hF00));
    end
    #2 reset = 1'b0;
    #1 chk("rst_async", 0, pack(1, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      chk("rst_after", j, pack(1, 0, 0, 0, 0, 0));
    end

    c = '{x0: 5, y0: 5, w: 2, h: 2, color: 'h777};
    run_cmd("post_reset", c, 0, c);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
